// File: rtl/stream_comparator.sv
// stream_comparator: two per-side FIFOs popped pairwise in lockstep, with saturating match/mismatch counters
// and sticky flags. Define STREAM_CMP_CAPTURE_EN to add first-mismatch capture outputs (first_a/first_b/first_idx).
module stream_comparator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int DEDUP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             cmp_valid,
  output logic             cmp_match,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             mismatch,
  output logic             overflow_a,
  output logic             overflow_b
`ifdef STREAM_CMP_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [CNT_W-1:0] first_idx
`endif
);

  // Handshake: a value is taken at a rising edge when *_valid=1 and *_ready=1. *_ready is a function of
  // registered occupancy only. *_valid with *_ready=0 never stalls: the value is dropped and overflow_* is set.

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];

  logic [PW-1:0]    wr_a_q, wr_a_d, rd_a_q, rd_a_d;
  logic [PW-1:0]    wr_b_q, wr_b_d, rd_b_q, rd_b_d;
  logic [WIDTH-1:0] hist_a_q, hist_a_d, hist_b_q, hist_b_d;
  logic             hist_a_vld_q, hist_a_vld_d, hist_b_vld_q, hist_b_vld_d;
  logic             cmp_valid_q, cmp_valid_d, cmp_match_q, cmp_match_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d, mism_cnt_q, mism_cnt_d;
  logic             mism_q, mism_d, ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;

  logic             flush;
  logic             empty_a, empty_b, full_a, full_b;
  logic             dup_a, dup_b, push_a, push_b, pop, same;
  logic [WIDTH-1:0] head_a, head_b;

  assign flush   = rst | clear;
  assign empty_a = (wr_a_q == rd_a_q);
  assign empty_b = (wr_b_q == rd_b_q);
  assign full_a  = (wr_a_q[AW] != rd_a_q[AW]) && (wr_a_q[AW-1:0] == rd_a_q[AW-1:0]);
  assign full_b  = (wr_b_q[AW] != rd_b_q[AW]) && (wr_b_q[AW-1:0] == rd_b_q[AW-1:0]);
  assign head_a  = mem_a_q[rd_a_q[AW-1:0]];
  assign head_b  = mem_b_q[rd_b_q[AW-1:0]];
  assign pop     = !empty_a && !empty_b;
  assign same    = (head_a == head_b);

  // A repeat of the last accepted value is swallowed before the full check, so it never flags overflow.
  assign dup_a  = (DEDUP != 0) && hist_a_vld_q && (a_data == hist_a_q);
  assign dup_b  = (DEDUP != 0) && hist_b_vld_q && (b_data == hist_b_q);
  assign push_a = a_valid && !dup_a && !full_a;
  assign push_b = b_valid && !dup_b && !full_b;

  always_comb begin
    wr_a_d       = wr_a_q;
    rd_a_d       = rd_a_q;
    wr_b_d       = wr_b_q;
    rd_b_d       = rd_b_q;
    hist_a_d     = hist_a_q;
    hist_a_vld_d = hist_a_vld_q;
    hist_b_d     = hist_b_q;
    hist_b_vld_d = hist_b_vld_q;
    cmp_valid_d  = pop;
    cmp_match_d  = cmp_match_q;
    match_cnt_d  = match_cnt_q;
    mism_cnt_d   = mism_cnt_q;
    mism_d       = mism_q;
    ovf_a_d      = ovf_a_q;
    ovf_b_d      = ovf_b_q;

    if (push_a) begin
      wr_a_d       = wr_a_q + PW'(1);
      hist_a_d     = a_data;
      hist_a_vld_d = 1'b1;
    end
    if (push_b) begin
      wr_b_d       = wr_b_q + PW'(1);
      hist_b_d     = b_data;
      hist_b_vld_d = 1'b1;
    end
    if (a_valid && !dup_a && full_a) ovf_a_d = 1'b1;
    if (b_valid && !dup_b && full_b) ovf_b_d = 1'b1;

    if (pop) begin
      rd_a_d      = rd_a_q + PW'(1);
      rd_b_d      = rd_b_q + PW'(1);
      cmp_match_d = same;
      if (same) begin
        if (match_cnt_q != CNT_MAX) match_cnt_d = match_cnt_q + CNT_W'(1);
      end else begin
        if (mism_cnt_q != CNT_MAX) mism_cnt_d = mism_cnt_q + CNT_W'(1);
        mism_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_a_q       <= '0;
      rd_a_q       <= '0;
      wr_b_q       <= '0;
      rd_b_q       <= '0;
      hist_a_q     <= '0;
      hist_a_vld_q <= 1'b0;
      hist_b_q     <= '0;
      hist_b_vld_q <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_match_q  <= 1'b0;
      match_cnt_q  <= '0;
      mism_cnt_q   <= '0;
      mism_q       <= 1'b0;
      ovf_a_q      <= 1'b0;
      ovf_b_q      <= 1'b0;
    end else begin
      wr_a_q       <= wr_a_d;
      rd_a_q       <= rd_a_d;
      wr_b_q       <= wr_b_d;
      rd_b_q       <= rd_b_d;
      hist_a_q     <= hist_a_d;
      hist_a_vld_q <= hist_a_vld_d;
      hist_b_q     <= hist_b_d;
      hist_b_vld_q <= hist_b_vld_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_match_q  <= cmp_match_d;
      match_cnt_q  <= match_cnt_d;
      mism_cnt_q   <= mism_cnt_d;
      mism_q       <= mism_d;
      ovf_a_q      <= ovf_a_d;
      ovf_b_q      <= ovf_b_d;
    end
  end

  // Storage is not flushed; emptied pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_a) mem_a_q[wr_a_q[AW-1:0]] <= a_data;
    if (push_b) mem_b_q[wr_b_q[AW-1:0]] <= b_data;
  end

  assign a_ready        = !full_a;
  assign b_ready        = !full_b;
  assign cmp_valid      = cmp_valid_q;
  assign cmp_match      = cmp_match_q;
  assign match_count    = match_cnt_q;
  assign mismatch_count = mism_cnt_q;
  assign mismatch       = mism_q;
  assign overflow_a     = ovf_a_q;
  assign overflow_b     = ovf_b_q;

`ifdef STREAM_CMP_CAPTURE_EN
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d, first_idx_q, first_idx_d;
  logic [WIDTH-1:0] first_a_q, first_a_d, first_b_q, first_b_d;

  // pair_cnt counts pairs compared so far, so it equals the index of the pair being compared now.
  always_comb begin
    pair_cnt_d  = pair_cnt_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
    first_idx_d = first_idx_q;
    if (pop) begin
      if (pair_cnt_q != CNT_MAX) pair_cnt_d = pair_cnt_q + CNT_W'(1);
      if (!same && !mism_q) begin
        first_a_d   = head_a;
        first_b_d   = head_b;
        first_idx_d = pair_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      pair_cnt_q  <= '0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_idx_q <= '0;
    end else begin
      pair_cnt_q  <= pair_cnt_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign first_a   = first_a_q;
  assign first_b   = first_b_q;
  assign first_idx = first_idx_q;
`endif

endmodule

// File: tb/tb_stream_comparator.sv
// Bench for stream_comparator: two instances (DEDUP=0/CNT_W=4 and DEDUP=1/CNT_W=16) share one stimulus stream
// and are checked against a queue-based reference model. Capture checks are active with STREAM_CMP_CAPTURE_EN.
module tb_stream_comparator;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, clear, a_valid, b_valid;
  logic [WIDTH-1:0] a_data, b_data;

  logic d_ar [2], d_br [2], d_cv [2], d_cm [2], d_mis [2], d_oa [2], d_ob [2];
  logic [3:0]  mc0, mmc0;
  logic [15:0] mc1, mmc1;
  logic [15:0] d_mc [2], d_mmc [2];
  assign d_mc[0]  = {12'h000, mc0};
  assign d_mc[1]  = mc1;
  assign d_mmc[0] = {12'h000, mmc0};
  assign d_mmc[1] = mmc1;

`ifdef STREAM_CMP_CAPTURE_EN
  logic [WIDTH-1:0] d_fa [2], d_fb [2];
  logic [3:0]  fi0;
  logic [15:0] fi1;
  logic [15:0] d_fi [2];
  assign d_fi[0] = {12'h000, fi0};
  assign d_fi[1] = fi1;
`endif

  stream_comparator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4), .DEDUP(0)) u0 (
    .clk(clk), .rst(rst), .clear(clear),
    .a_data(a_data), .a_valid(a_valid), .a_ready(d_ar[0]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(d_br[0]),
    .cmp_valid(d_cv[0]), .cmp_match(d_cm[0]),
    .match_count(mc0), .mismatch_count(mmc0), .mismatch(d_mis[0]),
    .overflow_a(d_oa[0]), .overflow_b(d_ob[0])
`ifdef STREAM_CMP_CAPTURE_EN
    , .first_a(d_fa[0]), .first_b(d_fb[0]), .first_idx(fi0)
`endif
  );

  stream_comparator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16), .DEDUP(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear),
    .a_data(a_data), .a_valid(a_valid), .a_ready(d_ar[1]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(d_br[1]),
    .cmp_valid(d_cv[1]), .cmp_match(d_cm[1]),
    .match_count(mc1), .mismatch_count(mmc1), .mismatch(d_mis[1]),
    .overflow_a(d_oa[1]), .overflow_b(d_ob[1])
`ifdef STREAM_CMP_CAPTURE_EN
    , .first_a(d_fa[1]), .first_b(d_fb[1]), .first_idx(fi1)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model (per instance index) ----------------
  int unsigned cmax [2] = '{15, 65535};
  bit          dd   [2] = '{1'b0, 1'b1};
  logic [WIDTH-1:0] m_a [2][$];
  logic [WIDTH-1:0] m_b [2][$];
  logic [WIDTH-1:0] m_ha [2], m_hb [2], m_fa [2], m_fb [2];
  bit          m_hav [2], m_hbv [2], m_cv [2], m_cm [2], m_mis [2], m_oa [2], m_ob [2];
  int unsigned m_mc [2], m_mmc [2], m_pairs [2], m_fi [2];

  logic [0:0] exp_q [$];
  bit sb_en = 1'b0;

  task automatic model_step();
    int sa, sb;
    logic [WIDTH-1:0] ha, hb;
    bit dup_a, dup_b, full_a, full_b;
    for (int i = 0; i < 2; i++) begin
      m_cv[i] = 1'b0;
      if (rst || clear) begin
        m_a[i].delete();
        m_b[i].delete();
        m_hav[i] = 1'b0; m_hbv[i] = 1'b0;
        m_mc[i] = 0; m_mmc[i] = 0; m_pairs[i] = 0;
        m_cm[i] = 1'b0; m_mis[i] = 1'b0; m_oa[i] = 1'b0; m_ob[i] = 1'b0;
        m_fa[i] = '0; m_fb[i] = '0; m_fi[i] = 0;
      end else begin
        sa = m_a[i].size();
        sb = m_b[i].size();
        full_a = (sa >= DEPTH);
        full_b = (sb >= DEPTH);
        dup_a = dd[i] && m_hav[i] && (a_data == m_ha[i]);
        dup_b = dd[i] && m_hbv[i] && (b_data == m_hb[i]);
        if (sa > 0 && sb > 0) begin
          ha = m_a[i].pop_front();
          hb = m_b[i].pop_front();
          m_cv[i] = 1'b1;
          m_cm[i] = (ha == hb);
          if (ha == hb) begin
            if (m_mc[i] < cmax[i]) m_mc[i]++;
          end else begin
            if (m_mmc[i] < cmax[i]) m_mmc[i]++;
            if (!m_mis[i]) begin
              m_fa[i] = ha; m_fb[i] = hb; m_fi[i] = m_pairs[i];
            end
            m_mis[i] = 1'b1;
          end
          if (m_pairs[i] < cmax[i]) m_pairs[i]++;
          if (sb_en && i == 0) exp_q.push_back(ha == hb);
        end
        if (a_valid && !dup_a) begin
          if (full_a) m_oa[i] = 1'b1;
          else begin m_a[i].push_back(a_data); m_ha[i] = a_data; m_hav[i] = 1'b1; end
        end
        if (b_valid && !dup_b) begin
          if (full_b) m_ob[i] = 1'b1;
          else begin m_b[i].push_back(b_data); m_hb[i] = b_data; m_hbv[i] = 1'b1; end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit av, input logic [WIDTH-1:0] ad, input bit bv, input logic [WIDTH-1:0] bd);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_data = 8'($urandom); b_data = 8'($urandom);
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (d_ar[i] !== 1'b1 || d_br[i] !== 1'b1) begin n_errors++; $display("FAIL reset_ready inst%0d: got a=%b b=%b want 1 1", i, d_ar[i], d_br[i]); end
      n_checks++; if (d_cv[i] !== 1'b0 || d_cm[i] !== 1'b0) begin n_errors++; $display("FAIL reset_cmp inst%0d: got v=%b m=%b want 0 0", i, d_cv[i], d_cm[i]); end
      n_checks++; if (d_mc[i] !== 16'd0 || d_mmc[i] !== 16'd0) begin n_errors++; $display("FAIL reset_cnt inst%0d: got %0d/%0d want 0/0", i, d_mc[i], d_mmc[i]); end
      n_checks++; if (d_mis[i] !== 1'b0 || d_oa[i] !== 1'b0 || d_ob[i] !== 1'b0) begin n_errors++; $display("FAIL reset_flags inst%0d: got %b%b%b want 000", i, d_mis[i], d_oa[i], d_ob[i]); end
`ifdef STREAM_CMP_CAPTURE_EN
      n_checks++; if (d_fa[i] !== 8'd0 || d_fb[i] !== 8'd0 || d_fi[i] !== 16'd0) begin n_errors++; $display("FAIL reset_capture inst%0d: got %0d %0d %0d want 0 0 0", i, d_fa[i], d_fb[i], d_fi[i]); end
`endif
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_basic();
    bit av [6], bv [6];
    logic [WIDTH-1:0] ad [6], bd [6];
    logic [7:0] pat [2];
    int n [2];
    av = '{1, 1, 1, 0, 0, 0}; ad = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0};
    bv = '{0, 1, 1, 1, 0, 0}; bd = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd0, 8'd0};
    pat = '{8'h00, 8'h00}; n = '{0, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(av[k], ad[k], bv[k], bd[k]);
      for (int i = 0; i < 2; i++)
        if (d_cv[i] === 1'b1) begin pat[i] = {pat[i][6:0], d_cm[i]}; n[i]++; end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (n[i] != 3 || pat[i][2:0] !== 3'b110) begin n_errors++; $display("FAIL basic_pairs inst%0d: got n=%0d pat=%b want n=3 pat=110", i, n[i], pat[i][2:0]); end
      n_checks++; if (d_mc[i] !== 16'd2 || d_mmc[i] !== 16'd1) begin n_errors++; $display("FAIL basic_cnt inst%0d: got %0d/%0d want 2/1", i, d_mc[i], d_mmc[i]); end
      n_checks++; if (d_mis[i] !== 1'b1) begin n_errors++; $display("FAIL basic_mismatch inst%0d: got %b want 1", i, d_mis[i]); end
    end
  endtask

  task automatic test_dedup();
    bit av [7], bv [7];
    logic [WIDTH-1:0] ad [7], bd [7];
    logic [7:0] pat [2];
    int n [2];
    int exp_mc [2] = '{1, 2};
    int exp_mmc [2] = '{1, 0};
    logic [1:0] exp_pat [2] = '{2'b10, 2'b11};
    av = '{1, 1, 1, 1, 0, 0, 0}; ad = '{8'd5, 8'd5, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0};
    bv = '{1, 1, 0, 0, 0, 0, 0}; bd = '{8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    pat = '{8'h00, 8'h00}; n = '{0, 0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(av[k], ad[k], bv[k], bd[k]);
      for (int i = 0; i < 2; i++)
        if (d_cv[i] === 1'b1) begin pat[i] = {pat[i][6:0], d_cm[i]}; n[i]++; end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (n[i] != 2 || pat[i][1:0] !== exp_pat[i]) begin n_errors++; $display("FAIL dedup_pairs inst%0d: got n=%0d pat=%b want n=2 pat=%b", i, n[i], pat[i][1:0], exp_pat[i]); end
      n_checks++; if (d_mc[i] !== 16'(exp_mc[i]) || d_mmc[i] !== 16'(exp_mmc[i])) begin n_errors++; $display("FAIL dedup_cnt inst%0d: got %0d/%0d want %0d/%0d", i, d_mc[i], d_mmc[i], exp_mc[i], exp_mmc[i]); end
      n_checks++; if (d_oa[i] !== 1'b0 || d_ob[i] !== 1'b0) begin n_errors++; $display("FAIL dedup_ovf inst%0d: got %b%b want 00", i, d_oa[i], d_ob[i]); end
    end
  endtask

  task automatic test_overflow();
    int n [2];
    int nm [2];
    n = '{0, 0}; nm = '{0, 0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 8'(10 + k), 1'b0, 8'd0);
      for (int i = 0; i < 2; i++) begin
        if (k == 2) begin
          n_checks++; if (d_ar[i] !== 1'b1) begin n_errors++; $display("FAIL ovf_ready3 inst%0d: got %b want 1", i, d_ar[i]); end
        end
        if (k == 3) begin
          n_checks++; if (d_ar[i] !== 1'b0 || d_oa[i] !== 1'b0) begin n_errors++; $display("FAIL ovf_full4 inst%0d: got ready=%b ovf=%b want 0 0", i, d_ar[i], d_oa[i]); end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (d_oa[i] !== 1'b1 || d_ob[i] !== 1'b0) begin n_errors++; $display("FAIL ovf_flag inst%0d: got a=%b b=%b want 1 0", i, d_oa[i], d_ob[i]); end
    end
    a_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 8'd0, (k < 4), 8'(10 + k));
      for (int i = 0; i < 2; i++)
        if (d_cv[i] === 1'b1) begin n[i]++; if (d_cm[i] === 1'b1) nm[i]++; end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (n[i] != 4 || nm[i] != 4) begin n_errors++; $display("FAIL ovf_drain inst%0d: got pairs=%0d matches=%0d want 4 4", i, n[i], nm[i]); end
      n_checks++; if (d_ar[i] !== 1'b1 || d_mc[i] !== 16'd4 || d_mmc[i] !== 16'd0) begin n_errors++; $display("FAIL ovf_empty inst%0d: got ready=%b cnt=%0d/%0d want 1 4/0", i, d_ar[i], d_mc[i], d_mmc[i]); end
    end
  endtask

  task automatic test_saturate();
    int exp_mc [2] = '{15, 20};
    do_reset();
    for (int k = 0; k < 20; k++) drive(1'b1, 8'(k + 1), 1'b1, 8'(k + 1));
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (d_mc[i] !== 16'(exp_mc[i]) || d_mmc[i] !== 16'd0) begin n_errors++; $display("FAIL sat_cnt inst%0d: got %0d/%0d want %0d/0", i, d_mc[i], d_mmc[i], exp_mc[i]); end
    end
  endtask

  task automatic test_clear();
    do_reset();
    drive(1'b1, 8'd1, 1'b1, 8'd2);
    drive(1'b1, 8'd3, 1'b0, 8'd0);
    drive(1'b1, 8'd4, 1'b0, 8'd0);
    drive(1'b1, 8'd5, 1'b1, 8'd9);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (d_mis[i] !== 1'b1 || d_mmc[i] !== 16'd1) begin n_errors++; $display("FAIL clr_pre inst%0d: got mis=%b mmc=%0d want 1 1", i, d_mis[i], d_mmc[i]); end
    end
    clear = 1'b1;
    drive(1'b0, 8'd0, 1'b1, 8'd8);
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (d_ar[i] !== 1'b1 || d_br[i] !== 1'b1 || d_cv[i] !== 1'b0) begin n_errors++; $display("FAIL clr_state inst%0d: got ar=%b br=%b cv=%b want 1 1 0", i, d_ar[i], d_br[i], d_cv[i]); end
      n_checks++; if (d_mc[i] !== 16'd0 || d_mmc[i] !== 16'd0 || d_mis[i] !== 1'b0 || d_oa[i] !== 1'b0) begin n_errors++; $display("FAIL clr_cnt inst%0d: got %0d/%0d mis=%b ovf=%b want 0/0 0 0", i, d_mc[i], d_mmc[i], d_mis[i], d_oa[i]); end
    end
    drive(1'b1, 8'd7, 1'b1, 8'd7);
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (d_cv[i] !== 1'b1 || d_cm[i] !== 1'b1 || d_mc[i] !== 16'd1 || d_mmc[i] !== 16'd0) begin n_errors++; $display("FAIL clr_fresh inst%0d: got cv=%b cm=%b cnt=%0d/%0d want 1 1 1/0", i, d_cv[i], d_cm[i], d_mc[i], d_mmc[i]); end
    end
  endtask

  task automatic test_capture();
    do_reset();
    drive(1'b1, 8'd1, 1'b1, 8'd1);
    drive(1'b1, 8'd2, 1'b1, 8'd9);
    drive(1'b1, 8'd3, 1'b1, 8'd8);
`ifdef STREAM_CMP_CAPTURE_EN
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (d_fa[i] !== 8'd2 || d_fb[i] !== 8'd9 || d_fi[i] !== 16'd1) begin n_errors++; $display("FAIL cap_first inst%0d: got %0d %0d %0d want 2 9 1", i, d_fa[i], d_fb[i], d_fi[i]); end
    end
`endif
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (d_mc[i] !== 16'd1 || d_mmc[i] !== 16'd2) begin n_errors++; $display("FAIL cap_cnt inst%0d: got %0d/%0d want 1/2", i, d_mc[i], d_mmc[i]); end
`ifdef STREAM_CMP_CAPTURE_EN
      n_checks++; if (d_fa[i] !== 8'd2 || d_fb[i] !== 8'd9 || d_fi[i] !== 16'd1) begin n_errors++; $display("FAIL cap_hold inst%0d: got %0d %0d %0d want 2 9 1", i, d_fa[i], d_fb[i], d_fi[i]); end
`endif
    end
  endtask

  task automatic test_random();
    int pa, pb;
    logic [0:0] e;
    do_reset();
    exp_q.delete();
    sb_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      pa = (c < 300) ? 70 : 30;
      pb = (c < 300) ? 30 : 70;
      rst     = ($urandom_range(0, 249) == 0);
      clear   = ($urandom_range(0, 99) == 0);
      a_valid = ($urandom_range(0, 99) < pa);
      b_valid = ($urandom_range(0, 99) < pb);
      a_data  = 8'($urandom_range(0, 3));
      b_data  = 8'($urandom_range(0, 3));
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (d_ar[i] !== (m_a[i].size() < DEPTH) || d_br[i] !== (m_b[i].size() < DEPTH)) begin n_errors++; $display("FAIL rnd_ready inst%0d cyc%0d: got %b%b want occ %0d/%0d", i, c, d_ar[i], d_br[i], m_a[i].size(), m_b[i].size()); end
        n_checks++; if (d_cv[i] !== m_cv[i] || (m_cv[i] && d_cm[i] !== m_cm[i])) begin n_errors++; $display("FAIL rnd_cmp inst%0d cyc%0d: got v=%b m=%b want v=%b m=%b", i, c, d_cv[i], d_cm[i], m_cv[i], m_cm[i]); end
        n_checks++; if (d_mc[i] !== 16'(m_mc[i]) || d_mmc[i] !== 16'(m_mmc[i])) begin n_errors++; $display("FAIL rnd_cnt inst%0d cyc%0d: got %0d/%0d want %0d/%0d", i, c, d_mc[i], d_mmc[i], m_mc[i], m_mmc[i]); end
        n_checks++; if (d_mis[i] !== m_mis[i] || d_oa[i] !== m_oa[i] || d_ob[i] !== m_ob[i]) begin n_errors++; $display("FAIL rnd_flags inst%0d cyc%0d: got %b%b%b want %b%b%b", i, c, d_mis[i], d_oa[i], d_ob[i], m_mis[i], m_oa[i], m_ob[i]); end
`ifdef STREAM_CMP_CAPTURE_EN
        n_checks++; if (d_fa[i] !== m_fa[i] || d_fb[i] !== m_fb[i] || d_fi[i] !== 16'(m_fi[i])) begin n_errors++; $display("FAIL rnd_capture inst%0d cyc%0d: got %0d %0d %0d want %0d %0d %0d", i, c, d_fa[i], d_fb[i], d_fi[i], m_fa[i], m_fb[i], m_fi[i]); end
`endif
      end
      if (d_cv[0] === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL rnd_sb cyc%0d: got unexpected cmp_valid, want no pending pair", c);
        end else begin
          e = exp_q.pop_front();
          if (d_cm[0] !== e) begin n_errors++; $display("FAIL rnd_sb cyc%0d: got match=%b want %b", c, d_cm[0], e); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rnd_sb_left: got %0d unconsumed results want 0", exp_q.size()); end
    sb_en = 1'b0;
    rst = 1'b0; clear = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; clear = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    test_reset();
    test_basic();
    test_dedup();
    test_overflow();
    test_saturate();
    test_clear();
    test_capture();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_comparator.md
# stream_comparator

Parametrised two-stream lockstep comparator: buffers values from two independent producers (e.g. reference model trace and DUT trace) in per-side FIFOs of configurable depth, pops them pairwise in order, and reports per-pair match results, saturating match/mismatch counters, and sticky error flags. It sits at the trace-check boundary of the testbench/debug fabric. Overflow is reported as a flag rather than halting simulation.

## Interface
Parameters:
- WIDTH, 8, bit width of compared values
- DEPTH, 4, entries per side FIFO; power of two, >= 2
- CNT_W, 16, width of match/mismatch counters
- DEDUP, 1, 1 = discard an accepted write equal to the previous accepted value on the same side; 0 = keep every write

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush: same effect as rst on all state
- a_data  in  WIDTH  stream A value
- a_valid  in  1  stream A write strobe
- a_ready  out  1  stream A FIFO not full
- b_data  in  WIDTH  stream B value
- b_valid  in  1  stream B write strobe
- b_ready  out  1  stream B FIFO not full
- cmp_valid  out  1  one-cycle pulse: a pair was compared
- cmp_match  out  1  result of that pair (valid with cmp_valid)
- match_count  out  CNT_W  saturating count of matching pairs
- mismatch_count  out  CNT_W  saturating count of mismatching pairs
- mismatch  out  1  sticky: any mismatch since reset/clear
- overflow_a  out  1  sticky: write to A while full
- overflow_b  out  1  sticky: write to B while full

## Operation
- Reset (rst or clear): FIFOs empty, a_ready=b_ready=1, cmp_valid=0, cmp_match=0, counters=0, mismatch=0, overflow_a/b=0, dedup history invalid. rst has priority; clear behaves identically.
- Write: a_valid accepted iff A occupancy < DEPTH at cycle start (a_ready=1). A pop in the same cycle does not free a slot for that cycle's write. a_valid with a_ready=0: value dropped, overflow_a set. Same for B.
- DEDUP=1: per side, a last-accepted register plus valid bit. Write equal to last-accepted value (valid bit set) is discarded, not pushed, not an overflow even if full. Otherwise value pushed (if space) and becomes last-accepted. History survives pops; cleared only by rst/clear. A dropped overflow write does not update history.
- Compare: in any cycle where both FIFOs are non-empty, both heads pop at the clock edge; registered cmp_valid=1, cmp_match=(headA==headB) in the following cycle. At most one pair per cycle; back-to-back pairs give continuous cmp_valid.
- On compare: match → match_count+1; mismatch → mismatch_count+1, mismatch=1. Counters saturate at 2^CNT_W-1.
- Wrap-around: read/write pointers are log2(DEPTH)+1 bits; full/empty from MSB comparison.

## Timing
- Data written at edge N is at FIFO head in cycle N+1; if the other side is non-empty, pops at edge N+1; cmp_valid/cmp_match/counters/mismatch visible after edge N+1. Write-to-result latency: 2 edges.
- a_ready/b_ready are registered-state functions (occupancy), no combinational path from inputs.
- Simultaneous A and B writes to empty FIFOs: both compared at the next edge.
- rst/clear mid-operation: pending entries discarded, no cmp_valid in the following cycle.

## Configuration
- STREAM_CMP_CAPTURE_EN defined: adds outputs first_a [WIDTH], first_b [WIDTH], first_idx [CNT_W]; on the first mismatch after reset/clear, captures both values and the zero-based pair index (total pairs compared before it, saturating); held until rst/clear; all zero after reset.
- Not defined: ports and capture logic absent; all other behaviour identical.

## Test plan
- DEPTH=4, DEDUP=0: A writes 1,2,3; B writes 1,2,4 one cycle later → three cmp_valid pulses, cmp_match 1,1,0; match_count=2, mismatch_count=1, mismatch=1.
- DEDUP=1: A writes 5,5,5,6; B writes 5,6 → two pairs, both match; match_count=2, no overflow.
- DEPTH=4: A writes 7 values with B idle → a_ready=0 after 4th, overflow_a=1, values 5–7 dropped; then B writes 4 matching values → 4 matches, FIFO empty.
- CNT_W=4: 20 matching pairs → match_count holds 15.
- Assert clear with 3 entries pending in A → next cycle a_ready=1, counters/flags 0, no cmp_valid; subsequent pairs compared from fresh state.
- STREAM_CMP_CAPTURE_EN: pairs (1,1),(2,9),(3,8) → first_a=2, first_b=9, first_idx=1, unchanged after third pair.
